ifetch_sram_axil: RTL and testbench
===================================

Name: ifetch_sram_axil

Overview:
- AXI-Lite read-only slave that models instruction memory directly downstream of the fetch stage's AR/R master.
- Accepts one fetch address, waits a programmable latency, then returns one 32-bit instruction word with an OKAY or SLVERR response.
- Has a side load port so the bench or boot logic can preload the program image.
- One outstanding transaction at a time, matching the fetch stage's one-request-per-instruction protocol.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, read data width; fixed 32 for RV32 instructions.
- DEPTH_LOG2, 12, log2 of memory depth in 32-bit words (default 4096 words = 16 KiB).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- READ_LAT, 2, cycles from AR handshake to first r_valid; legal range 1..15.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- s_ar_valid_i  in  1  read address valid
- s_ar_addr_i  in  ADDR_W  read byte address
- s_ar_ready_o  out  1  read address ready
- s_r_valid_o  out  1  read data valid
- s_r_data_o  out  DATA_W  read data
- s_r_resp_o  out  2  read response; 2'b00 OKAY, 2'b10 SLVERR
- s_r_ready_i  in  1  read data ready
- ld_we_i  in  1  preload write enable
- ld_idx_i  in  DEPTH_LOG2  preload word index
- ld_data_i  in  DATA_W  preload word

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- States (one-hot):
  - IDLE: s_ar_ready_o=1.
  - BUSY: latency countdown.
  - RESP: s_r_valid_o=1.
- Reset:
  - state forced to IDLE and counter cleared.
  - r_data register = 0, r_resp register = 2'b00.
  - First cycle after reset: s_ar_ready_o=1, s_r_valid_o=0.
  - Memory array is not reset.
  - Reset asserted in BUSY or RESP abandons the transaction; no response is ever emitted for it.
- Address handshake (ar_hs): ar_hs = s_ar_valid_i & s_ar_ready_o. On ar_hs in cycle T:
  - latch the address;
  - load the counter with d-1, where d = READ_LAT (plus extra delay if the optional feature is enabled);
  - next state is RESP if d-1==0, otherwise BUSY.
- BUSY: counter decrements each cycle; when counter==1 the next state is RESP. First s_r_valid_o is in cycle T+d.
- Error check, evaluated on the latched address:
  - error if addr[1:0]!=0;
  - error if addr < BASE_ADDR;
  - error if (addr-BASE_ADDR)>>2 >= 2**DEPTH_LOG2.
- Data capture on entry to RESP:
  - Error case: r_data=0, r_resp=2'b10.
  - Otherwise: r_data = mem[(addr-BASE_ADDR)>>2], r_resp=2'b00.
- RESP:
  - s_r_data_o and s_r_resp_o are held stable until s_r_ready_i.
  - r_hs = s_r_valid_o & s_r_ready_i; on r_hs the next state is IDLE.
- s_ar_ready_o is 0 in BUSY and RESP. A new AR is accepted no earlier than the cycle after r_hs; no combinational ready-through.
- s_ar_valid_i during BUSY/RESP is ignored (not queued).
- Preload port:
  - mem[ld_idx_i] <= ld_data_i on ld_we_i, in any state.
  - A same-cycle preload to the word being captured on RESP entry returns the OLD value (read-before-write).
  - After capture, preloads never alter held r_data.
- Arithmetic: address subtraction is done in ADDR_W bits; the borrow flags addr < BASE_ADDR. The index is truncated to DEPTH_LOG2 only after the range check passes.

Optional Feature:
- Macro: IFETCH_SRAM_RAND_DELAY_EN.
- With the macro:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded 8'hA5 on reset and advances every cycle.
  - On ar_hs, d = READ_LAT + lfsr[3:0], giving latency READ_LAT..READ_LAT+15. The counter widens to 5 bits.
  - This stresses the fetch stage's WAIT_BUS_RSP handling.
- Without the macro: no LFSR logic; d = READ_LAT exactly.

Test Plan:
- Preload idx0=32'h0000_0413, READ_LAT=2, s_r_ready_i=1; AR addr 32'h8000_0000 accepted at cycle 0 -> s_r_valid_o=1 at cycle 2, data 32'h0000_0413, resp 2'b00; s_ar_ready_o=1 again at cycle 3.
- Same read with s_r_ready_i held low 3 cycles after valid -> data and resp stable all 4 valid cycles; s_ar_ready_o=0 throughout; a second s_ar_valid_i in that window is not accepted.
- AR addr 32'h7FFF_FFFC -> resp 2'b10, data 0. AR addr 32'h8000_0002 -> resp 2'b10. AR addr BASE+4*4096 -> resp 2'b10.
- Preload idx5=32'hDEAD_BEEF, then in the capture cycle preload idx5=32'h1234_5678 -> returns 32'hDEAD_BEEF; a subsequent read of idx5 returns 32'h1234_5678.
- rst_i pulsed 1 cycle while in BUSY -> s_r_valid_o stays 0, s_ar_ready_o=1 the cycle after reset, next read completes normally.
- IFETCH_SRAM_RAND_DELAY_EN defined, 100 back-to-back reads -> every latency in [READ_LAT, READ_LAT+15] and equal to a bench LFSR model seeded 8'hA5; data always correct.

Source files
------------

// File: rtl/ifetch_sram_axil.sv
// Read-only AXI-Lite instruction memory with programmable latency and a side preload port.
// Define IFETCH_SRAM_RAND_DELAY_EN to add LFSR-driven extra latency of 0..15 cycles per fetch.
module ifetch_sram_axil #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                READ_LAT   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_ar_valid_i,
  input  logic [ADDR_W-1:0]     s_ar_addr_i,
  output logic                  s_ar_ready_o,
  output logic                  s_r_valid_o,
  output logic [DATA_W-1:0]     s_r_data_o,
  output logic [1:0]            s_r_resp_o,
  input  logic                  s_r_ready_i,
  input  logic                  ld_we_i,
  input  logic [DEPTH_LOG2-1:0] ld_idx_i,
  input  logic [DATA_W-1:0]     ld_data_i
);

`ifdef IFETCH_SRAM_RAND_DELAY_EN
  localparam int CW = 5;
`else
  localparam int CW = 4;
`endif
  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    BUSY = 3'b010,
    RESP = 3'b100
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           d_m1;
  logic [ADDR_W-1:0]       addr_q;
  logic [ADDR_W-1:0]       cap_addr;
  logic [ADDR_W-1:0]       off;
  logic                    borrow;
  logic                    cap_err;
  logic [DEPTH_LOG2-1:0]   cap_idx;
  logic                    ar_hs;
  logic                    r_hs;
  logic [DATA_W-1:0]       mem [WORDS];

`ifdef IFETCH_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR, taps 8,6,5,4
  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign d_m1 = CW'(READ_LAT) + CW'(lfsr[3:0]) - CW'(1);
`else
  assign d_m1 = CW'(READ_LAT - 1);
`endif

  assign ar_hs = s_ar_valid_i & s_ar_ready_o;
  assign r_hs  = s_r_valid_o & s_r_ready_i;

  // With a one-cycle latency the capture happens in the handshake cycle, before addr_q is loaded.
  assign cap_addr         = (state == IDLE) ? s_ar_addr_i : addr_q;
  assign {borrow, off}    = {1'b0, cap_addr} - {1'b0, BASE_ADDR};
  assign cap_err          = (cap_addr[1:0] != 2'b00) | borrow |
                            ((off >> (DEPTH_LOG2 + 2)) != '0);
  assign cap_idx          = off[DEPTH_LOG2+1:2];

  always_ff @(posedge clk_i) begin
    if (ld_we_i) mem[ld_idx_i] <= ld_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      s_ar_ready_o <= 1'b1;
      s_r_valid_o  <= 1'b0;
      s_r_data_o   <= '0;
      s_r_resp_o   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (ar_hs) begin
            addr_q       <= s_ar_addr_i;
            cnt          <= d_m1;
            s_ar_ready_o <= 1'b0;
            if (d_m1 == '0) begin
              state       <= RESP;
              s_r_valid_o <= 1'b1;
              s_r_data_o  <= cap_err ? '0 : mem[cap_idx];
              s_r_resp_o  <= cap_err ? 2'b10 : 2'b00;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt <= CW'(1)) begin
            cnt         <= '0;
            state       <= RESP;
            s_r_valid_o <= 1'b1;
            s_r_data_o  <= cap_err ? '0 : mem[cap_idx];
            s_r_resp_o  <= cap_err ? 2'b10 : 2'b00;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (r_hs) begin
            state        <= IDLE;
            s_r_valid_o  <= 1'b0;
            s_ar_ready_o <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          cnt          <= '0;
          s_r_valid_o  <= 1'b0;
          s_ar_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_sram_axil.sv
// Scoreboard bench for ifetch_sram_axil: directed fetches, error responses, backpressure,
// read-before-write capture, reset abandonment and (with IFETCH_SRAM_RAND_DELAY_EN) random latency.
module tb_ifetch_sram_axil;
  localparam int          RL   = 2;
  localparam int          DL   = 12;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          s_ar_valid_i;
  logic [31:0]   s_ar_addr_i;
  logic          s_ar_ready_o;
  logic          s_r_valid_o;
  logic [31:0]   s_r_data_o;
  logic [1:0]    s_r_resp_o;
  logic          s_r_ready_i;
  logic          ld_we_i;
  logic [DL-1:0] ld_idx_i;
  logic [31:0]   ld_data_i;

  ifetch_sram_axil #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(DL), .BASE_ADDR(BASE), .READ_LAT(RL)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_ar_valid_i(s_ar_valid_i), .s_ar_addr_i(s_ar_addr_i), .s_ar_ready_o(s_ar_ready_o),
    .s_r_valid_o(s_r_valid_o), .s_r_data_o(s_r_data_o), .s_r_resp_o(s_r_resp_o),
    .s_r_ready_i(s_r_ready_i),
    .ld_we_i(ld_we_i), .ld_idx_i(ld_idx_i), .ld_data_i(ld_data_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          hs;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [7:0] m_lfsr = 8'hA5;
  bit   in_resp = 0;

  always @(posedge clk_i) begin
    cyc    <= cyc + 1;
    m_lfsr <= rst_i ? 8'hA5 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every valid response cycle against the front of the scoreboard.
  always @(negedge clk_i) begin
    if (rst_i) begin
      in_resp = 0;
    end else if (s_r_valid_o) begin
      check("ar_ready_low_in_resp", 32'(s_ar_ready_o), 32'd0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got data %h resp %0d with no request pending (cycle %0d)",
                 s_r_data_o, s_r_resp_o, cyc);
      end else begin
        if (!in_resp) begin
          in_resp = 1;
          check("latency", 32'(cyc - q[0].hs), 32'(q[0].lat));
        end
        check("r_data", s_r_data_o, q[0].data);
        check("r_resp", 32'(s_r_resp_o), 32'(q[0].resp));
        if (s_r_ready_i) begin
          void'(q.pop_front());
          in_resp = 0;
        end
      end
    end
  end

  // All stimulus tasks are entered and left at posedge+#1.
  task automatic preload(input int idx, input logic [31:0] d);
    ld_we_i   = 1'b1;
    ld_idx_i  = DL'(idx);
    ld_data_i = d;
    @(posedge clk_i); #1;
    ld_we_i = 1'b0;
  endtask

  task automatic issue_ar(input logic [31:0] addr, input logic [31:0] d, input logic [1:0] r,
                          input bit push, output int lat);
    int n;
    exp_t e;
    n = 0;
    s_ar_valid_i = 1'b1;
    s_ar_addr_i  = addr;
    while (!s_ar_ready_o && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!s_ar_ready_o) begin
      checks++;
      errors++;
      $display("FAIL ar_accept_timeout: ready still %0d after %0d cycles, required 1", s_ar_ready_o, n);
    end
`ifdef IFETCH_SRAM_RAND_DELAY_EN
    lat = RL + int'(m_lfsr[3:0]);
`else
    lat = RL;
`endif
    e = '{data: d, resp: r, hs: cyc, lat: lat};
    if (push) q.push_back(e);
    @(posedge clk_i); #1;
    s_ar_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: %0d responses outstanding after %0d cycles, required 0", q.size(), n);
      q.delete();
    end
  endtask

  initial begin
    int lat;
    int idx;
    rst_i        = 1'b1;
    s_ar_valid_i = 1'b0;
    s_ar_addr_i  = '0;
    s_r_ready_i  = 1'b1;
    ld_we_i      = 1'b0;
    ld_idx_i     = '0;
    ld_data_i    = '0;
    @(posedge clk_i); #1;
    preload(0, 32'h0000_0413);
    preload(5, 32'hDEAD_BEEF);
    preload(4095, 32'hCAFE_F00D);
    for (int i = 8; i < 16; i++) preload(i, 32'h1000_0000 + 32'(i) * 32'h11);
    rst_i = 1'b0;
    // First cycle after reset is observed here (reset sampled by the previous edge).
    check("rst_ar_ready", 32'(s_ar_ready_o), 32'd1);
    check("rst_r_valid", 32'(s_r_valid_o), 32'd0);
    check("rst_r_data", s_r_data_o, 32'd0);
    check("rst_r_resp", 32'(s_r_resp_o), 32'd0);

    // Basic fetch
    issue_ar(BASE, 32'h0000_0413, 2'b00, 1, lat);
    wait_idle();
    check("ar_ready_after_rhs", 32'(s_ar_ready_o), 32'd1);

    // Backpressure: ready low for 3 valid cycles, a competing AR and a preload meanwhile
    s_r_ready_i = 1'b0;
    issue_ar(BASE, 32'h0000_0413, 2'b00, 1, lat);
    s_ar_valid_i = 1'b1;
    s_ar_addr_i  = BASE + 32'd20;
    for (int n = 0; n < 300 && !s_r_valid_o; n++) begin
      @(posedge clk_i); #1;
    end
    preload(0, 32'hFFFF_0000);
    repeat (2) begin
      @(posedge clk_i); #1;
    end
    s_r_ready_i  = 1'b1;
    s_ar_valid_i = 1'b0;
    wait_idle();
    check("ar_ready_after_hold", 32'(s_ar_ready_o), 32'd1);
    issue_ar(BASE, 32'hFFFF_0000, 2'b00, 1, lat);
    wait_idle();

    // Error responses and the last valid word
    issue_ar(32'h7FFF_FFFC, 32'h0, 2'b10, 1, lat);
    wait_idle();
    issue_ar(32'h8000_0002, 32'h0, 2'b10, 1, lat);
    wait_idle();
    issue_ar(32'h8000_4000, 32'h0, 2'b10, 1, lat);
    wait_idle();
    issue_ar(32'hFFFF_FFFC, 32'h0, 2'b10, 1, lat);
    wait_idle();
    issue_ar(32'h8000_3FFC, 32'hCAFE_F00D, 2'b00, 1, lat);
    wait_idle();

    // Preload landing in the capture cycle returns the old word
    issue_ar(BASE + 32'd20, 32'hDEAD_BEEF, 2'b00, 1, lat);
    repeat (lat - 2) begin
      @(posedge clk_i); #1;
    end
    preload(5, 32'h1234_5678);
    wait_idle();
    issue_ar(BASE + 32'd20, 32'h1234_5678, 2'b00, 1, lat);
    wait_idle();

    // Reset while BUSY abandons the fetch
    issue_ar(BASE, 32'h0, 2'b00, 0, lat);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("busy_rst_ar_ready", 32'(s_ar_ready_o), 32'd1);
    check("busy_rst_r_valid", 32'(s_r_valid_o), 32'd0);
    repeat (20) begin
      @(posedge clk_i); #1;
    end
    issue_ar(BASE + 32'd32, 32'h1000_0088, 2'b00, 1, lat);
    wait_idle();

    // 100 back-to-back fetches over words 8..15
    for (int i = 0; i < 100; i++) begin
      idx = 8 + (i % 8);
      issue_ar(BASE + 32'(idx) * 32'd4, 32'h1000_0000 + 32'(idx) * 32'h11, 2'b00, 1, lat);
      if (lat < RL || lat > RL + 15) begin
        checks++;
        errors++;
        $display("FAIL latency_range: got %0d required %0d..%0d", lat, RL, RL + 15);
      end
    end
    wait_idle();
    repeat (3) begin
      @(posedge clk_i); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
